// File: rtl/dma_pkg.sv
// Shared PCIe read-path types and helpers for the request splitter and the
// completion tracker.
package dma_pkg;

    typedef enum logic [2:0] {
        CPL_STATUS_SC  = 3'b000,
        CPL_STATUS_UR  = 3'b001,
        CPL_STATUS_CRS = 3'b010,
        CPL_STATUS_CA  = 3'b100
    } cpl_status_e;

    // Largest single read request and the default max read request size
    localparam int unsigned MAX_REQ_BYTES      = 4096;
    localparam int unsigned MAX_READ_REQ_BYTES = 512;

    typedef struct packed {
        logic [31:0] base;
        logic [12:0] size;
        logic [12:0] rem;
    } tag_entry_t;

    // Completion byte count field: zero encodes a full 4 KiB
    function automatic logic [12:0] decode_byte_count(input logic [11:0] bc);
        return (bc == 12'd0) ? 13'd4096 : {1'b0, bc};
    endfunction

    // Payload length in DWs to bytes: zero encodes 1024 DWs
    function automatic logic [12:0] dw_to_bytes(input logic [9:0] len_dw);
        return (len_dw == 10'd0) ? 13'd4096 : {1'b0, len_dw, 2'b00};
    endfunction

endpackage

// File: rtl/dma_tag_table.sv
// Outstanding read request table: busy flags, lowest-free allocator,
// per-tag base/size/remaining storage and a registered busy count.
module dma_tag_table
    import dma_pkg::*;
#(
    parameter int unsigned NUM_TAGS = 4,
    parameter int unsigned TAG_W    = $clog2(NUM_TAGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_en_i,
    input  logic [31:0]      alloc_base_i,
    input  logic [12:0]      alloc_size_i,
    output logic             free_avail_o,
    output logic [TAG_W-1:0] free_tag_o,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_busy_o,
    output tag_entry_t       rd_entry_o,
    input  logic             upd_en_i,
    input  logic [TAG_W-1:0] upd_tag_i,
    input  logic [12:0]      upd_rem_i,
    input  logic             upd_free_i,
    input  logic             flush_i,
    output logic [TAG_W:0]   outstanding_o
);

    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [TAG_W:0]      outstanding_q, outstanding_d;
    tag_entry_t          entry_q [NUM_TAGS];
    logic                alloc_fire;

    // Priority encoder picking the lowest idle tag
    always_comb begin
        logic found;
        found      = 1'b0;
        free_tag_o = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (!busy_q[i] && !found) begin
                found      = 1'b1;
                free_tag_o = TAG_W'(i);
            end
        end
        free_avail_o = found;
    end

    assign alloc_fire    = alloc_en_i && free_avail_o;
    assign rd_busy_o     = busy_q[rd_tag_i];
    assign rd_entry_o    = entry_q[rd_tag_i];
    assign outstanding_o = outstanding_q;

    // Next busy vector (release, then flush, then allocation) and its popcount
    always_comb begin
        busy_d = busy_q;
        if (upd_en_i && upd_free_i) busy_d[upd_tag_i] = 1'b0;
        if (flush_i) busy_d = '0;
        if (alloc_fire) busy_d[free_tag_o] = 1'b1;
        outstanding_d = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            outstanding_d = outstanding_d + (TAG_W+1)'(busy_d[i]);
        end
    end

    // Table storage; allocation and update never target the same tag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            for (int unsigned i = 0; i < NUM_TAGS; i++) entry_q[i] <= '0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            if (upd_en_i) entry_q[upd_tag_i].rem <= upd_rem_i;
            if (alloc_fire) begin
                entry_q[free_tag_o] <= '{base: alloc_base_i, size: alloc_size_i, rem: alloc_size_i};
            end
        end
    end

endmodule

// File: rtl/dma_completion_tracker.sv
// Receive-side completion tracker: tags read requests, matches returning
// completions, emits device write descriptors and completion/error pulses.
module dma_completion_tracker
    import dma_pkg::*;
#(
    parameter int unsigned NUM_TAGS       = 4,
    parameter int unsigned TAG_W          = $clog2(NUM_TAGS),
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_address_device,
    input  logic [12:0]      req_size,
    input  logic             cpl_valid,
    output logic             cpl_ready,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [2:0]       cpl_status,
    input  logic [11:0]      cpl_byte_count,
    input  logic [9:0]       cpl_length_dw,
    input  logic [6:0]       cpl_lower_addr,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [31:0]      wr_address,
    output logic [12:0]      wr_bytes,
    output logic             wr_last,
    output logic             req_done,
    output logic [TAG_W-1:0] req_done_tag,
    output logic [TAG_W:0]   outstanding,
    output logic             err_status,
    output logic             err_unexpected,
    output logic             err_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic             tt_busy;
    tag_entry_t       tt_entry;
    logic [12:0]      bc, pay, nbytes;
    logic             last, unexpected, status_err;
    logic             cpl_accept, good, bad_status, upd_en, upd_free, timeout_fire;
    logic [4:0]       unused_lower_addr;

    logic             wr_valid_q, wr_last_q, req_done_q;
    logic [31:0]      wr_address_q;
    logic [12:0]      wr_bytes_q;
    logic [TAG_W-1:0] req_done_tag_q;
    logic             err_status_q, err_unexpected_q, err_timeout_q;
    logic [WD_W-1:0]  wd_q;

    // Only the byte offset within the first DW shortens the payload
    assign unused_lower_addr = cpl_lower_addr[6:2];

    assign cpl_ready  = !wr_valid_q || wr_ready;
    assign cpl_accept = cpl_valid && cpl_ready;

    assign bc         = decode_byte_count(cpl_byte_count);
    assign pay        = dw_to_bytes(cpl_length_dw) - {11'd0, cpl_lower_addr[1:0]};
    assign nbytes     = (bc < pay) ? bc : pay;
    assign last       = (bc <= pay);
    assign unexpected = !tt_busy || (bc != tt_entry.rem);
    assign status_err = cpl_status_e'(cpl_status) != CPL_STATUS_SC;

    assign good         = cpl_accept && !unexpected && !status_err;
    assign bad_status   = cpl_accept && !unexpected && status_err;
    assign upd_en       = good || bad_status;
    assign upd_free     = bad_status || last;
    assign timeout_fire = (outstanding != '0) && !cpl_accept
                          && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    dma_tag_table #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_W    (TAG_W)
    ) u_tag_table (
        .clk_i         (i_clk),
        .rst_ni        (i_rst_n),
        .alloc_en_i    (req_valid),
        .alloc_base_i  (req_address_device),
        .alloc_size_i  (req_size),
        .free_avail_o  (req_ready),
        .free_tag_o    (req_tag),
        .rd_tag_i      (cpl_tag),
        .rd_busy_o     (tt_busy),
        .rd_entry_o    (tt_entry),
        .upd_en_i      (upd_en),
        .upd_tag_i     (cpl_tag),
        .upd_rem_i     (tt_entry.rem - nbytes),
        .upd_free_i    (upd_free),
        .flush_i       (timeout_fire),
        .outstanding_o (outstanding)
    );

    // Write descriptor register, completion/error pulses and watchdog
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_valid_q       <= 1'b0;
            wr_address_q     <= '0;
            wr_bytes_q       <= '0;
            wr_last_q        <= 1'b0;
            req_done_q       <= 1'b0;
            req_done_tag_q   <= '0;
            err_status_q     <= 1'b0;
            err_unexpected_q <= 1'b0;
            err_timeout_q    <= 1'b0;
            wd_q             <= '0;
        end else begin
            req_done_q       <= upd_en && upd_free;
            req_done_tag_q   <= cpl_tag;
            err_status_q     <= bad_status;
            err_unexpected_q <= cpl_accept && unexpected;
            err_timeout_q    <= timeout_fire;
            if (good) begin
                wr_valid_q   <= 1'b1;
                wr_address_q <= tt_entry.base + {19'd0, tt_entry.size - bc};
                wr_bytes_q   <= nbytes;
                wr_last_q    <= last;
            end else if (wr_ready) begin
                wr_valid_q   <= 1'b0;
            end
            if (cpl_accept || outstanding == '0 || timeout_fire) wd_q <= '0;
            else wd_q <= wd_q + 1'b1;
        end
    end

    assign wr_valid       = wr_valid_q;
    assign wr_address     = wr_address_q;
    assign wr_bytes       = wr_bytes_q;
    assign wr_last        = wr_last_q;
    assign req_done       = req_done_q;
    assign req_done_tag   = req_done_tag_q;
    assign err_status     = err_status_q;
    assign err_unexpected = err_unexpected_q;
    assign err_timeout    = err_timeout_q;

endmodule
